// File: rtl/ififo_skew_bank_pkg.sv
`default_nettype none
// ============================================================================
// ififo_skew_bank_pkg : delivery-mode encoding and width helper for the bank
// Revision: 1.0
// ============================================================================
package ififo_skew_bank_pkg;

  typedef enum logic {
    MODE_BCAST = 1'b0,
    MODE_SKEW  = 1'b1
  } mode_e;

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_lane.sv
`default_nettype none
// ============================================================================
// fifo_lane : single-clock lane FIFO with registered read data and valid strobe
// Revision: 1.0
// ============================================================================
module fifo_lane
  import ififo_skew_bank_pkg::*;
#(
  parameter int BW    = 4,
  parameter int DEPTH = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr,
  input  logic [BW-1:0] in,
  input  logic          rd,
  output logic [BW-1:0] out,
  output logic          out_valid,
  output logic          o_full,
  output logic          o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic [BW-1:0] r_mem [DEPTH];
  logic          w_acc_wr;
  logic          w_acc_rd;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign o_empty  = (r_wptr == r_rptr);
  assign o_full   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_acc_rd = rd & ~o_empty;
  assign w_acc_wr = wr & (~o_full | w_acc_rd);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= w_acc_rd;
      if (w_acc_wr) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_acc_rd) begin
        r_rptr <= r_rptr + (AW+1)'(1);
        out    <= r_mem[r_rptr[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc_wr) r_mem[r_wptr[AW-1:0]] <= in;
  end

endmodule
`default_nettype wire

// File: rtl/ififo_skew_bank.sv
`default_nettype none
// ============================================================================
// ififo_skew_bank : ROW-lane input FIFO bank with skewed or broadcast launch
// Revision: 1.0
// ============================================================================
module ififo_skew_bank
  import ififo_skew_bank_pkg::*;
#(
  parameter int ROW   = 8,
  parameter int BW    = 4,
  parameter int DEPTH = 64,
  parameter int CW    = cnt_width(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ROW*BW-1:0] in,
  input  logic              wr,
  input  logic              rd,
  input  logic              skew_en,
  output logic [ROW*BW-1:0] out,
  output logic [ROW-1:0]    out_valid,
  output logic              o_full,
  output logic              o_ready,
  output logic              o_empty,
  output logic              o_busy,
  output logic [CW-1:0]     count,
  output logic              o_err
);

  logic [ROW-1:0]    r_chain;
  logic [ROW-1:0]    w_chain_nxt;
  logic [CW-1:0]     r_count;
  mode_e             r_mode;
  logic              r_err;
  logic              w_acc_wr;
  logic              w_acc_rd;
  logic [ROW-1:0]    w_pop;
  logic [ROW-1:0]    w_lane_full;
  logic [ROW-1:0]    w_lane_empty;
  logic [ROW-1:0]    w_lane_vld;
  logic [ROW*BW-1:0] w_lane_data;

  // Lane ROW-1 drains last and never holds fewer entries than any other lane,
  // so the OR is exactly its full flag.
  assign o_full   = |w_lane_full;
  assign o_ready  = ~o_full;
  assign o_empty  = (r_count == '0);
  assign o_busy   = |r_chain;
  assign count    = r_count;
  assign o_err    = r_err;
  assign w_acc_wr = wr & ~o_full;
  assign w_acc_rd = rd & ~o_empty;
  assign w_pop    = r_chain & ~w_lane_empty;

  always_comb begin
    w_chain_nxt    = '0;
    w_chain_nxt[0] = w_acc_rd;
    for (int i = 1; i < ROW; i++) begin
      w_chain_nxt[i] = (r_mode == MODE_SKEW) ? r_chain[i-1] : w_acc_rd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_chain <= '0;
      r_mode  <= MODE_BCAST;
      r_err   <= 1'b0;
    end else begin
      r_count <= r_count + CW'(w_acc_wr) - CW'(w_acc_rd);
      r_chain <= w_chain_nxt;
      // Mode only changes with the chain empty, so a launch never mixes modes.
      if (!o_busy && !w_acc_rd) r_mode <= mode_e'(skew_en);
      if ((wr && o_full) || (rd && o_empty)) r_err <= 1'b1;
    end
  end

  for (genvar gi = 0; gi < ROW; gi++) begin : g_lane
    fifo_lane #(
      .BW    (BW),
      .DEPTH (DEPTH)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .wr        (w_acc_wr),
      .in        (in[gi*BW +: BW]),
      .rd        (w_pop[gi]),
      .out       (w_lane_data[gi*BW +: BW]),
      .out_valid (w_lane_vld[gi]),
      .o_full    (w_lane_full[gi]),
      .o_empty   (w_lane_empty[gi])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out       <= '0;
      out_valid <= '0;
    end else begin
      out_valid <= w_lane_vld;
      for (int i = 0; i < ROW; i++) begin
        if (w_lane_vld[i]) out[i*BW +: BW] <= w_lane_data[i*BW +: BW];
      end
    end
  end

endmodule
`default_nettype wire
